// File: rtl/mm_pkg.sv
// Shared definitions for the matching-memory controller: FSM encoding,
// allocation-mode selectors and a constant clog2 helper.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        STALL = 2'd2
    } mm_state_e;

    localparam int ALLOC_LOWEST = 0;
    localparam int ALLOC_RR     = 1;

    function automatic int mm_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/mm_prio_enc.sv
// First-set-bit encoder that starts its search at a given index and wraps
// around; idx is only meaningful when found is high.
module mm_prio_enc
    import mm_pkg::*;
#(
    parameter  int N = 64,
    localparam int W = mm_clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;

    // Rotate so that bit 'start' lands at position 0, then take the lowest set bit.
    always_comb begin
        dbl   = {vec, vec} >> start;
        rot   = dbl[N-1:0];
        off   = '0;
        found = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = W'(i);
        end
        idx = off + start;
    end

endmodule

// File: rtl/mm_match_alloc_ctrl.sv
// MMCAM matching-memory controller: resolves fire / allocate / bypass per
// accepted packet into a one-deep registered decision with valid/ready flow.
module mm_match_alloc_ctrl
    import mm_pkg::*;
#(
    parameter  int DEPTH      = 64,
    parameter  int ALLOC_MODE = 0,
    parameter  int CNT_W      = 16,
    localparam int AW         = mm_clog2(DEPTH)
) (
    input  logic             CP,
    input  logic             MR,
    input  logic [DEPTH-1:0] FIRE,
    input  logic [DEPTH-1:0] VALID,
    input  logic             MF,
    input  logic             IN_V,
    output logic             IN_R,
    output logic             OUT_V,
    input  logic             OUT_R,
    output logic             WR_E,
    output logic             DEL,
    output logic [AW-1:0]    ADDR,
    output logic [DEPTH-1:0] EN,
    output logic             FULL,
    output logic [AW:0]      OCC,
    output logic             MULTI_HIT,
    output logic [CNT_W-1:0] OVF_CNT
);

    localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

    mm_state_e        state, state_d;
    logic [AW-1:0]    rr_ptr, rr_ptr_d;
    logic [AW-1:0]    fire_idx, free_idx, free_start;
    logic             fire_found, free_found, fire_multi;
    logic             out_v_d, wr_e_d, del_d, multi_d;
    logic [AW-1:0]    addr_d;
    logic [DEPTH-1:0] en_d;
    logic [CNT_W-1:0] ovf_d;
    logic [AW:0]      occ_d;
    logic             eval, eval_mf;

    assign free_start = (ALLOC_MODE == ALLOC_RR) ? rr_ptr : '0;
    assign fire_multi = |(FIRE & (FIRE - ONE));

    mm_prio_enc #(.N(DEPTH)) u_fire_enc (
        .vec   (FIRE),
        .start ('0),
        .idx   (fire_idx),
        .found (fire_found)
    );

    mm_prio_enc #(.N(DEPTH)) u_free_enc (
        .vec   (~VALID),
        .start (free_start),
        .idx   (free_idx),
        .found (free_found)
    );

    assign IN_R = (state == IDLE) || ((state == BUSY) && OUT_R);

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + (AW+1)'(VALID[i]);
        end
    end

    // A stalled packet is always a matching packet, so STALL re-evaluates with MF forced.
    always_comb begin
        state_d  = state;
        out_v_d  = OUT_V;
        wr_e_d   = WR_E;
        del_d    = DEL;
        addr_d   = ADDR;
        en_d     = '0;
        multi_d  = MULTI_HIT;
        ovf_d    = OVF_CNT;
        rr_ptr_d = rr_ptr;
        eval     = 1'b0;
        eval_mf  = MF;

        unique case (state)
            IDLE:  eval = IN_V;
            BUSY: begin
                if (OUT_R) begin
                    if (IN_V) begin
                        eval = 1'b1;
                    end else begin
                        state_d = IDLE;
                        out_v_d = 1'b0;
                    end
                end
            end
            STALL: begin
                eval    = 1'b1;
                eval_mf = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (eval) begin
            if (!eval_mf) begin
                state_d = BUSY;
                out_v_d = 1'b1;
                wr_e_d  = 1'b0;
                del_d   = 1'b0;
            end else if (fire_found) begin
                state_d = BUSY;
                out_v_d = 1'b1;
                wr_e_d  = 1'b0;
                del_d   = 1'b1;
                addr_d  = fire_idx;
                multi_d = MULTI_HIT | fire_multi;
            end else if (free_found) begin
                state_d = BUSY;
                out_v_d = 1'b1;
                wr_e_d  = 1'b1;
                del_d   = 1'b0;
                addr_d  = free_idx;
                en_d    = ONE << free_idx;
                if (ALLOC_MODE == ALLOC_RR) rr_ptr_d = free_idx + AW'(1);
            end else begin
                state_d = STALL;
                out_v_d = 1'b0;
                wr_e_d  = 1'b0;
                del_d   = 1'b0;
                if ((state == STALL) && (OVF_CNT != '1)) ovf_d = OVF_CNT + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CP or negedge MR) begin
        if (!MR) begin
            state     <= IDLE;
            OUT_V     <= 1'b0;
            WR_E      <= 1'b0;
            DEL       <= 1'b1;
            ADDR      <= '0;
            EN        <= '0;
            FULL      <= 1'b0;
            OCC       <= '0;
            MULTI_HIT <= 1'b0;
            OVF_CNT   <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_d;
            OUT_V     <= out_v_d;
            WR_E      <= wr_e_d;
            DEL       <= del_d;
            ADDR      <= addr_d;
            EN        <= en_d;
            FULL      <= &VALID;
            OCC       <= occ_d;
            MULTI_HIT <= multi_d;
            OVF_CNT   <= ovf_d;
            rr_ptr    <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_mm_match_alloc_ctrl.sv
// Directed bench: lowest-free and round-robin 64-entry controllers share one
// stimulus stream; a 4-entry round-robin controller covers the small-depth wrap.
module tb_mm_match_alloc_ctrl;

    localparam int D = 64;
    localparam logic [63:0] ALL1 = '1;

    logic cp = 1'b0;
    logic mr = 1'b0;

    logic [D-1:0] fire, valid;
    logic         mf, in_v, out_r;

    logic         a_in_r, a_out_v, a_wr_e, a_del, a_full, a_multi;
    logic [5:0]   a_addr;
    logic [D-1:0] a_en;
    logic [6:0]   a_occ;
    logic [15:0]  a_ovf;

    logic         r_in_r, r_out_v, r_wr_e, r_del, r_full, r_multi;
    logic [5:0]   r_addr;
    logic [D-1:0] r_en;
    logic [6:0]   r_occ;
    logic [15:0]  r_ovf;

    logic [3:0]   w_fire, w_valid;
    logic         w_mf, w_in_v, w_out_r;
    logic         w_in_r, w_out_v, w_wr_e, w_del, w_full, w_multi;
    logic [1:0]   w_addr;
    logic [3:0]   w_en;
    logic [2:0]   w_occ;
    logic [15:0]  w_ovf;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic        in_v, mf, out_r;
        logic [63:0] fire, valid;
        logic        chk_dec;
        logic        out_v, wr_e, del, en_pulse, in_r, multi;
        logic [5:0]  addr_lo, addr_rr;
    } vec_t;

    vec_t vecs[14];

    always #5 cp = ~cp;

    mm_match_alloc_ctrl #(.DEPTH(64), .ALLOC_MODE(0), .CNT_W(16)) u_lo (
        .CP(cp), .MR(mr), .FIRE(fire), .VALID(valid), .MF(mf), .IN_V(in_v),
        .IN_R(a_in_r), .OUT_V(a_out_v), .OUT_R(out_r), .WR_E(a_wr_e), .DEL(a_del),
        .ADDR(a_addr), .EN(a_en), .FULL(a_full), .OCC(a_occ), .MULTI_HIT(a_multi),
        .OVF_CNT(a_ovf)
    );

    mm_match_alloc_ctrl #(.DEPTH(64), .ALLOC_MODE(1), .CNT_W(16)) u_rr (
        .CP(cp), .MR(mr), .FIRE(fire), .VALID(valid), .MF(mf), .IN_V(in_v),
        .IN_R(r_in_r), .OUT_V(r_out_v), .OUT_R(out_r), .WR_E(r_wr_e), .DEL(r_del),
        .ADDR(r_addr), .EN(r_en), .FULL(r_full), .OCC(r_occ), .MULTI_HIT(r_multi),
        .OVF_CNT(r_ovf)
    );

    mm_match_alloc_ctrl #(.DEPTH(4), .ALLOC_MODE(1), .CNT_W(16)) u_w4 (
        .CP(cp), .MR(mr), .FIRE(w_fire), .VALID(w_valid), .MF(w_mf), .IN_V(w_in_v),
        .IN_R(w_in_r), .OUT_V(w_out_v), .OUT_R(w_out_r), .WR_E(w_wr_e), .DEL(w_del),
        .ADDR(w_addr), .EN(w_en), .FULL(w_full), .OCC(w_occ), .MULTI_HIT(w_multi),
        .OVF_CNT(w_ovf)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        in_v  = v.in_v;
        mf    = v.mf;
        out_r = v.out_r;
        fire  = v.fire;
        valid = v.valid;
        tick();
    endtask

    function automatic vec_t mk(input logic iv, m, orr, input logic [63:0] f, vl,
                                input logic chk, ov, we, dl, enp, ir, mh,
                                input logic [5:0] al, ar);
        vec_t v;
        v.in_v = iv;  v.mf = m;  v.out_r = orr;  v.fire = f;  v.valid = vl;
        v.chk_dec = chk;  v.out_v = ov;  v.wr_e = we;  v.del = dl;
        v.en_pulse = enp;  v.in_r = ir;  v.multi = mh;
        v.addr_lo = al;  v.addr_rr = ar;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(1,1,1, 64'h0,   64'h0,    1, 1,1,0,1, 1,0,  0,  0);
        vecs[1]  = mk(1,1,1, 64'h0,   64'h0,    1, 1,1,0,1, 1,0,  0,  1);
        vecs[2]  = mk(1,1,1, 64'h0,   64'h0,    1, 1,1,0,1, 1,0,  0,  2);
        vecs[3]  = mk(1,1,1, 64'h0,   64'h18,   1, 1,1,0,1, 1,0,  0,  5);
        vecs[4]  = mk(1,1,1, 64'h30,  64'h0,    1, 1,0,1,0, 1,1,  4,  4);
        vecs[5]  = mk(1,1,1, 64'h100, 64'h0,    1, 1,0,1,0, 1,1,  8,  8);
        vecs[6]  = mk(1,0,1, 64'hF,   ALL1,     1, 1,0,0,0, 1,1,  8,  8);
        vecs[7]  = mk(0,1,1, 64'h0,   64'h0,    0, 0,0,0,0, 1,1,  0,  0);
        vecs[8]  = mk(1,1,1, 64'h0,   ~64'h44,  1, 1,1,0,1, 1,1,  2,  6);
        vecs[9]  = mk(1,1,1, 64'h0,   ~64'h44,  1, 1,1,0,1, 1,1,  2,  2);
        vecs[10] = mk(1,1,1, 64'h8000_0000_0000_0000, 64'h0, 1, 1,0,1,0, 1,1, 63, 63);
        vecs[11] = mk(0,1,0, 64'h0,   64'h0,    1, 1,0,1,0, 0,1, 63, 63);
        vecs[12] = mk(0,1,0, 64'h0,   64'h0,    1, 1,0,1,0, 0,1, 63, 63);
        vecs[13] = mk(0,1,1, 64'h0,   64'h0,    0, 0,0,0,0, 1,1,  0,  0);

        fire = '0;  valid = '0;  mf = 1'b0;  in_v = 1'b0;  out_r = 1'b1;
        w_fire = '0;  w_valid = '0;  w_mf = 1'b0;  w_in_v = 1'b0;  w_out_r = 1'b1;

        // Reset state
        #12;
        checkOutput("rst out_v", a_out_v, 0);
        checkOutput("rst del",   a_del,   1);
        checkOutput("rst wr_e",  a_wr_e,  0);
        checkOutput("rst in_r",  a_in_r,  1);
        checkOutput("rst occ",   a_occ,   0);
        checkOutput("rst addr",  a_addr,  0);
        checkOutput("rst en",    a_en,    0);
        checkOutput("rst ovf",   a_ovf,   0);
        tick();
        mr = 1'b1;

        // Table-driven decisions
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d out_v", i), a_out_v, vecs[i].out_v);
            checkOutput($sformatf("v%0d in_r", i),  a_in_r,  vecs[i].in_r);
            checkOutput($sformatf("v%0d multi", i), a_multi, vecs[i].multi);
            checkOutput($sformatf("v%0d occ", i),   a_occ,   64'($countones(vecs[i].valid)));
            checkOutput($sformatf("v%0d full", i),  a_full,  &vecs[i].valid);
            checkOutput($sformatf("v%0d en_lo", i), a_en,
                        vecs[i].en_pulse ? (64'd1 << vecs[i].addr_lo) : 64'd0);
            checkOutput($sformatf("v%0d en_rr", i), r_en,
                        vecs[i].en_pulse ? (64'd1 << vecs[i].addr_rr) : 64'd0);
            if (vecs[i].chk_dec) begin
                checkOutput($sformatf("v%0d wr_e", i),    a_wr_e, vecs[i].wr_e);
                checkOutput($sformatf("v%0d del", i),     a_del,  vecs[i].del);
                checkOutput($sformatf("v%0d addr_lo", i), a_addr, vecs[i].addr_lo);
                checkOutput($sformatf("v%0d addr_rr", i), r_addr, vecs[i].addr_rr);
                checkOutput($sformatf("v%0d rr_del", i),  r_del,  vecs[i].del);
            end
        end

        // Full table: stall, count, then a freed entry resolves the packet
        in_v = 1'b1;  mf = 1'b1;  out_r = 1'b1;  fire = '0;  valid = ALL1;
        tick();
        checkOutput("stall out_v", a_out_v, 0);
        checkOutput("stall in_r",  a_in_r,  0);
        checkOutput("stall wr_e",  a_wr_e,  0);
        checkOutput("stall del",   a_del,   0);
        checkOutput("stall en",    a_en,    0);
        checkOutput("stall ovf0",  a_ovf,   0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput($sformatf("stall ovf%0d", k), a_ovf, k);
            checkOutput($sformatf("stall in_r%0d", k), r_in_r, 0);
        end
        valid = ALL1 & ~(64'd1 << 17);
        tick();
        checkOutput("unstall out_v", a_out_v, 1);
        checkOutput("unstall wr_e",  a_wr_e,  1);
        checkOutput("unstall addr",  a_addr,  17);
        checkOutput("unstall rr",    r_addr,  17);
        checkOutput("unstall en",    a_en,    64'd1 << 17);
        checkOutput("unstall ovf",   a_ovf,   5);

        // Downstream backpressure holds the decision without repeating EN
        in_v = 1'b0;  out_r = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("hold%0d out_v", k), a_out_v, 1);
            checkOutput($sformatf("hold%0d wr_e", k),  a_wr_e,  1);
            checkOutput($sformatf("hold%0d addr", k),  a_addr,  17);
            checkOutput($sformatf("hold%0d en", k),    a_en,    0);
            checkOutput($sformatf("hold%0d in_r", k),  a_in_r,  0);
        end
        out_r = 1'b1;  in_v = 1'b1;  mf = 1'b0;  valid = '0;
        tick();
        checkOutput("bypass out_v", a_out_v, 1);
        checkOutput("bypass wr_e",  a_wr_e,  0);
        checkOutput("bypass del",   a_del,   0);
        checkOutput("bypass addr",  a_addr,  17);
        checkOutput("bypass en",    r_en,    0);
        in_v = 1'b0;
        tick();
        checkOutput("idle out_v", a_out_v, 0);

        // Asynchronous reset in the middle of a stall
        in_v = 1'b1;  mf = 1'b1;  fire = '0;  valid = ALL1;
        tick();
        tick();
        tick();
        checkOutput("pre-rst ovf", a_ovf, 7);
        #2;
        mr = 1'b0;
        #1;
        checkOutput("mid-rst out_v", a_out_v, 0);
        checkOutput("mid-rst ovf",   a_ovf,   0);
        checkOutput("mid-rst del",   a_del,   1);
        checkOutput("mid-rst in_r",  a_in_r,  1);
        checkOutput("mid-rst multi", a_multi, 0);
        valid = '0;
        @(negedge cp);
        mr = 1'b1;
        tick();
        checkOutput("post-rst out_v", a_out_v, 1);
        checkOutput("post-rst wr_e",  a_wr_e,  1);
        checkOutput("post-rst rr",    r_addr,  0);
        checkOutput("post-rst en",    r_en,    64'd1);
        in_v = 1'b0;
        tick();

        // Four-entry round-robin: pointer wrap and two-bit addressing
        w_in_v = 1'b1;  w_mf = 1'b1;  w_out_r = 1'b1;  w_fire = '0;  w_valid = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("w4 alloc%0d addr", k), w_addr, k % 4);
            checkOutput($sformatf("w4 alloc%0d en", k),   w_en,   4'd1 << (k % 4));
            checkOutput($sformatf("w4 alloc%0d wr_e", k), w_wr_e, 1);
        end
        w_valid = 4'b1110;
        tick();
        checkOutput("w4 wrap addr", w_addr, 0);
        w_valid = 4'b1111;
        tick();
        checkOutput("w4 stall out_v", w_out_v, 0);
        checkOutput("w4 stall in_r",  w_in_r,  0);
        checkOutput("w4 full",        w_full,  1);
        checkOutput("w4 occ",         w_occ,   4);
        w_fire = 4'b0100;
        tick();
        checkOutput("w4 fire out_v", w_out_v, 1);
        checkOutput("w4 fire del",   w_del,   1);
        checkOutput("w4 fire addr",  w_addr,  2);
        checkOutput("w4 fire en",    w_en,    0);
        checkOutput("w4 multi",      w_multi, 0);
        w_in_v = 1'b0;
        tick();
        checkOutput("w4 idle out_v", w_out_v, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/mm_match_alloc_ctrl.md
Name: mm_match_alloc_ctrl

Overview:
- Parametrised matching-memory controller for the MMCAM stage of the data-driven pipeline.
- Per accepted packet, resolves CAM search results (FIRE) and entry occupancy (VALID) into one of three decisions: fire/delete, wait/allocate, or bypass.
- Buffers the decision in a one-deep output register with a valid/ready handshake.
- Stalls, without dropping the packet, when an allocation finds the table full.
- Adds depth generalisation, round-robin allocation, backpressure, and overflow/multi-hit status.

Parameters:
- DEPTH, 64: number of CAM entries; power of two, 4 to 256.
- ALLOC_MODE, 0: 0 = lowest-index free entry; 1 = round-robin search from RR_PTR.
- CNT_W, 16: width of the saturating overflow-stall counter.
- AW (localparam), clog2(DEPTH): address width.

Ports:
- CP  in  1  clock, rising edge
- MR  in  1  reset, asynchronous, active-low
- FIRE  in  DEPTH  CAM match hits for the presented packet
- VALID  in  DEPTH  entry occupied (waiting) flags
- MF  in  1  packet requires matching
- IN_V  in  1  upstream packet valid
- IN_R  out  1  upstream ready
- OUT_V  out  1  decision valid
- OUT_R  in  1  downstream ready
- WR_E  out  1  write packet into entry ADDR
- DEL  out  1  read and delete entry ADDR (fire)
- ADDR  out  AW  entry address
- EN  out  DEPTH  one-hot entry write enable, single-cycle pulse
- FULL  out  1  registered: all VALID set
- OCC  out  AW+1  registered popcount(VALID)
- MULTI_HIT  out  1  sticky: an accepted fire had more than one FIRE bit set
- OVF_CNT  out  CNT_W  saturating count of STALL cycles

Behaviour:
- Reset (MR=0, asynchronous) sets:
  - state=IDLE, OUT_V=0, WR_E=0, DEL=1 (stage entry-clear convention), ADDR=0
  - EN=0, FULL=0, OCC=0, MULTI_HIT=0, OVF_CNT=0, RR_PTR=0
- Reset asserted mid-operation discards any pending or stalled packet. The first accept is possible on the first CP edge after MR rises.
- IN_R = (state==IDLE) or (state==BUSY and OUT_R). IN_R is registered-state only and never depends on IN_V.
- An accept is IN_V and IN_R at a CP edge. The decision is registered on that edge: one-cycle latency, and OUT_V rises the next cycle.
- Decision priority, evaluated on the accept edge:
  - MF=1 and |FIRE: DEL=1, WR_E=0, ADDR = lowest set FIRE index. MULTI_HIT is set if popcount(FIRE)>1.
  - MF=1, FIRE=0, free entry exists: WR_E=1, DEL=0, ADDR = allocated index, EN = 1<<ADDR for exactly one cycle. If ALLOC_MODE=1, RR_PTR <= (ADDR+1) mod DEPTH.
  - MF=1, FIRE=0, VALID all ones: go to STALL. OUT_V=0, WR_E=0, DEL=0, EN=0.
  - MF=0 (bypass): WR_E=0, DEL=0, ADDR holds its previous value, EN=0, OUT_V=1. FIRE and VALID are ignored.
- Fire always beats allocation when both are possible.
- Round-robin search begins at RR_PTR, wraps from DEPTH-1 to 0, and selects the first clear VALID bit.
- States:
  - IDLE: on accept, go to BUSY, or to STALL for the full-table case.
  - BUSY: OUT_V=1 and outputs held stable while OUT_R=0.
    - OUT_R=1 with a new accept: re-evaluate, back-to-back at one decision per cycle.
    - OUT_R=1 without an accept: go to IDLE, OUT_V=0.
  - STALL: IN_R=0. Upstream holds the packet, so FIRE and VALID are re-sampled every cycle.
    - |FIRE: resolve as fire, go to BUSY.
    - A VALID bit clears: allocate, go to BUSY with an EN pulse.
    - Otherwise: stay, and OVF_CNT increments, saturating at all ones.
- EN pulses only on the edge entering BUSY with an allocation. It never repeats while BUSY is held by OUT_R=0.
- FULL and OCC are registered from VALID every cycle, independent of state.
- DEPTH=4 edge: the RR_PTR wrap and AW=2 must work.

Decomposition:
- Shared package mm_pkg:
  - state encoding IDLE/BUSY/STALL
  - ALLOC_LOWEST=0, ALLOC_RR=1
  - clog2 helper
- Sub-module mm_prio_enc:
  - parametrised first-set-bit encoder with start pointer and wrap, plus found flag
  - instantiated twice: FIRE with start 0; inverted VALID with start 0 or RR_PTR

Test Plan:
- Reset then idle, DEPTH=64 -> OUT_V=0, DEL=1, IN_R=1, OCC=0. Release MR, then IN_V=1, MF=1, FIRE=0, VALID=0 -> next cycle OUT_V=1, WR_E=1, ADDR=0, EN=64'h1 for one cycle.
- FIRE=64'h0000_0000_0000_0030, MF=1 -> DEL=1, ADDR=4, MULTI_HIT=1 (sticky after later single hits).
- ALLOC_MODE=1, three allocations with VALID=0 each time -> ADDR=0, 1, 2; RR_PTR=3. With VALID bits 3 and 4 set, the next allocation -> ADDR=5.
- VALID all ones, MF=1, FIRE=0 -> STALL, IN_R=0, OVF_CNT counts 5 over 5 cycles. Clear VALID[17] -> BUSY, WR_E=1, ADDR=17, EN bit 17 pulse.
- OUT_R=0 for 3 cycles in BUSY -> outputs stable, EN pulsed once, IN_R=0. OUT_R=1 with IN_V=1, MF=0 -> bypass with ADDR unchanged, WR_E=0, DEL=0.
- MR low during STALL -> immediate IDLE, OUT_V=0, OVF_CNT=0, DEL=1.
